// File: rtl/iq_agc_pkg.sv
// rtl/iq_agc_pkg.sv - shared types and helpers for the I/Q automatic gain control stage
// Contents: FSM state encoding, gain decision encoding, unity-gain and saturation-limit helpers.
package iq_agc_pkg;

    typedef enum logic [1:0] {
        ACC_ST    = 2'd0,
        EVAL_ST   = 2'd1,
        UPDATE_ST = 2'd2
    } agc_state_t;

    typedef enum logic [1:0] {
        DEC_HOLD = 2'd0,
        DEC_UP   = 2'd1,
        DEC_DOWN = 2'd2
    } agc_dec_t;

    // Gain code representing 1.0 for a given number of fractional bits.
    function automatic int gain_unity(input int frac);
        return 1 << frac;
    endfunction

    // Symmetric saturation magnitude for a two's complement width (most negative code excluded).
    function automatic int sat_limit(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/iq_scale_sat.sv
// rtl/iq_scale_sat.sv - two-stage signed sample scaler: multiply, round-half-up, symmetric saturate
// Ports: clk, reset (async, active-high); x (signed sample), gain (unsigned fixed point);
//        load_1 captures the product, load_2 captures the rounded/saturated result; y (signed result).
module iq_scale_sat
    import iq_agc_pkg::*;
#(
    parameter int DATA_WIDTH_IQ = 10,
    parameter int GAIN_WIDTH    = 12,
    parameter int GAIN_FRAC     = 8
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH_IQ-1:0] x,
    input  logic [GAIN_WIDTH-1:0]    gain,
    input  logic                     load_1,
    input  logic                     load_2,
    output logic [DATA_WIDTH_IQ-1:0] y
);

    localparam int PW = DATA_WIDTH_IQ + GAIN_WIDTH + 1;
    localparam logic signed [PW-1:0] HALF  = PW'(1) << (GAIN_FRAC - 1);
    localparam logic signed [PW-1:0] LIM_P = PW'(sat_limit(DATA_WIDTH_IQ));
    localparam logic signed [PW-1:0] LIM_N = -LIM_P;

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic [DATA_WIDTH_IQ-1:0] y_next;

    always_comb begin
        x_ext     = PW'($signed(x));
        // Gain is unsigned; a zero MSB keeps it positive in the signed product.
        g_ext     = PW'($signed({1'b0, gain}));
        prod_next = x_ext * g_ext;
    end

    always_comb begin
        rounded = prod + HALF;
        shifted = rounded >>> GAIN_FRAC;
        if (shifted > LIM_P) begin
            y_next = LIM_P[DATA_WIDTH_IQ-1:0];
        end else if (shifted < LIM_N) begin
            y_next = LIM_N[DATA_WIDTH_IQ-1:0];
        end else begin
            y_next = shifted[DATA_WIDTH_IQ-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= '0;
            y    <= '0;
        end else begin
            if (load_1) begin
                prod <= prod_next;
            end
            if (load_2) begin
                y <= y_next;
            end
        end
    end

endmodule

// File: rtl/iq_agc.sv
// rtl/iq_agc.sv - automatic gain control for signed I/Q samples with lock-driven gain freeze
// Ports: clk, reset (async, active-high); I_data_i/Q_data_i/data_val_i input samples;
//        target_i/hyst_i level target and dead band; freeze_i holds gain;
//        I_data_o/Q_data_o/data_val_o scaled samples (2-cycle latency); gain_o current gain;
//        settled_o gain unchanged for SETTLE_WIN consecutive windows.
module iq_agc
    import iq_agc_pkg::*;
#(
    parameter int DATA_WIDTH_IQ = 10,
    parameter int GAIN_WIDTH    = 12,
    parameter int GAIN_FRAC     = 8,
    parameter int WIN_LOG2      = 8,
    parameter int STEP_SHIFT    = 4,
    parameter int SETTLE_WIN    = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH_IQ-1:0] I_data_i,
    input  logic [DATA_WIDTH_IQ-1:0] Q_data_i,
    input  logic                     data_val_i,
    input  logic [DATA_WIDTH_IQ-1:0] target_i,
    input  logic [DATA_WIDTH_IQ-1:0] hyst_i,
    input  logic                     freeze_i,
    output logic [DATA_WIDTH_IQ-1:0] I_data_o,
    output logic [DATA_WIDTH_IQ-1:0] Q_data_o,
    output logic                     data_val_o,
    output logic [GAIN_WIDTH-1:0]    gain_o,
    output logic                     settled_o
);

    localparam int ACC_W = DATA_WIDTH_IQ + WIN_LOG2;
    localparam int SET_W = $clog2(SETTLE_WIN + 1);
    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX  = '1;
    localparam logic [GAIN_WIDTH-1:0] GAIN_ONE  = GAIN_WIDTH'(gain_unity(GAIN_FRAC));
    localparam logic [SET_W-1:0]      SET_FULL  = SET_W'(SETTLE_WIN);

    agc_state_t state;
    agc_dec_t   dec;

    logic                     v1, e1, v2, e2;
    logic                     epoch;
    logic [GAIN_WIDTH-1:0]    gain;
    logic [ACC_W-1:0]         acc;
    logic [WIN_LOG2-1:0]      cnt;
    logic [SET_W-1:0]         settle;

    logic [DATA_WIDTH_IQ-1:0] abs_i, abs_q, sample_mag;
    logic [DATA_WIDTH_IQ-1:0] mean;
    logic [DATA_WIDTH_IQ:0]   upper;
    logic                     want_up, want_down;
    logic [GAIN_WIDTH-1:0]    step;
    logic [GAIN_WIDTH:0]      up_sum;
    logic [GAIN_WIDTH-1:0]    gain_next;

    iq_scale_sat #(
        .DATA_WIDTH_IQ (DATA_WIDTH_IQ),
        .GAIN_WIDTH    (GAIN_WIDTH),
        .GAIN_FRAC     (GAIN_FRAC)
    ) u_scale_i (
        .clk    (clk),
        .reset  (reset),
        .x      (I_data_i),
        .gain   (gain),
        .load_1 (data_val_i),
        .load_2 (v1),
        .y      (I_data_o)
    );

    iq_scale_sat #(
        .DATA_WIDTH_IQ (DATA_WIDTH_IQ),
        .GAIN_WIDTH    (GAIN_WIDTH),
        .GAIN_FRAC     (GAIN_FRAC)
    ) u_scale_q (
        .clk    (clk),
        .reset  (reset),
        .x      (Q_data_i),
        .gain   (gain),
        .load_1 (data_val_i),
        .load_2 (v1),
        .y      (Q_data_o)
    );

    // Valid and gain-epoch travel alongside the datapath so the measurement can
    // reject samples that were multiplied by a gain that is no longer current.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
            v2 <= 1'b0;
            e2 <= 1'b0;
        end else begin
            v1 <= data_val_i;
            e1 <= epoch;
            v2 <= v1;
            e2 <= e1;
        end
    end

    // Outputs are saturated symmetrically, so negation never overflows here.
    always_comb begin
        abs_i      = I_data_o[DATA_WIDTH_IQ-1] ? -I_data_o : I_data_o;
        abs_q      = Q_data_o[DATA_WIDTH_IQ-1] ? -Q_data_o : Q_data_o;
        sample_mag = abs_i + abs_q;
    end

    always_comb begin
        mean      = acc[ACC_W-1:WIN_LOG2];
        upper     = {1'b0, target_i} + {1'b0, hyst_i};
        // Lower bound floors at zero: with target <= hyst nothing is ever below it.
        want_up   = (target_i > hyst_i) && (mean < (target_i - hyst_i));
        want_down = ({1'b0, mean} > upper);
    end

    always_comb begin
        step = gain >> STEP_SHIFT;
        if (step == '0) begin
            step = GAIN_WIDTH'(1);
        end
        up_sum    = {1'b0, gain} + {1'b0, step};
        gain_next = gain;
        case (dec)
            DEC_UP:   gain_next = up_sum[GAIN_WIDTH] ? GAIN_MAX : up_sum[GAIN_WIDTH-1:0];
            DEC_DOWN: gain_next = (gain <= step) ? GAIN_WIDTH'(1) : (gain - step);
            default:  gain_next = gain;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ACC_ST;
            dec    <= DEC_HOLD;
            gain   <= GAIN_ONE;
            epoch  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            settle <= '0;
        end else begin
            case (state)
                ACC_ST: begin
                    if (v2 && (e2 == epoch)) begin
                        acc <= acc + ACC_W'(sample_mag);
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state <= EVAL_ST;
                        end
                    end
                end
                EVAL_ST: begin
                    if (freeze_i) begin
                        dec <= DEC_HOLD;
                    end else if (want_up) begin
                        dec <= DEC_UP;
                    end else if (want_down) begin
                        dec <= DEC_DOWN;
                    end else begin
                        dec <= DEC_HOLD;
                    end
                    state <= UPDATE_ST;
                end
                UPDATE_ST: begin
                    gain <= gain_next;
                    // A clamped adjustment that leaves gain unchanged counts as stable.
                    if (gain_next != gain) begin
                        epoch  <= ~epoch;
                        settle <= '0;
                    end else if (settle != SET_FULL) begin
                        settle <= settle + 1'b1;
                    end
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ACC_ST;
                end
                default: begin
                    state <= ACC_ST;
                end
            endcase
        end
    end

    assign data_val_o = v2;
    assign gain_o     = gain;
    assign settled_o  = (settle == SET_FULL);

endmodule

// File: tb/tb_iq_agc.sv
// tb/tb_iq_agc.sv - scoreboard bench for iq_agc with directed windows and hand-computed results
module tb_iq_agc;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [9:0] i_in, q_in;
    logic              val_in;
    logic [9:0]        target, hyst;
    logic              freeze;
    logic signed [9:0] i_out, q_out;
    logic              val_out;
    logic [11:0]       gain;
    logic              settled;

    iq_agc #(
        .DATA_WIDTH_IQ (10),
        .GAIN_WIDTH    (12),
        .GAIN_FRAC     (8),
        .WIN_LOG2      (4),
        .STEP_SHIFT    (4),
        .SETTLE_WIN    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .I_data_i   (i_in),
        .Q_data_i   (q_in),
        .data_val_i (val_in),
        .target_i   (target),
        .hyst_i     (hyst),
        .freeze_i   (freeze),
        .I_data_o   (i_out),
        .Q_data_o   (q_out),
        .data_val_o (val_out),
        .gain_o     (gain),
        .settled_o  (settled)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int i;
        int q;
        int when;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Gain after each convergence window (I=Q=50, target 200, hyst 4) and the output level at each gain.
    int conv_gain [13] = '{256, 272, 289, 307, 326, 346, 367, 389, 413, 438, 465, 494, 524};
    int conv_out  [12] = '{50, 53, 56, 60, 64, 68, 72, 76, 81, 86, 91, 96};

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (val_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got I=%0d Q=%0d expected no output", i_out, q_out);
            end else begin
                e = sb.pop_front();
                check("out_i", int'(i_out), e.i);
                check("out_q", int'(q_out), e.q);
                check("latency_cycle", cyc, e.when);
            end
        end
    end

    task automatic drive(input int i, input int q, input int ei, input int eq);
        exp_t e;
        @(posedge clk); #1;
        i_in   = 10'(i);
        q_in   = 10'(q);
        val_in = 1'b1;
        e.i    = ei;
        e.q    = eq;
        e.when = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            val_in = 1'b0;
        end
    endtask

    // One full 16-sample measurement window followed by enough idle for the gain update.
    task automatic window(input int i, input int q, input int ei, input int eq);
        repeat (16) drive(i, q, ei, eq);
        idle(8);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset  = 1'b1;
        val_in = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        reset  = 1'b1;
        val_in = 1'b0;
        i_in   = '0;
        q_in   = '0;
        target = 10'd200;
        hyst   = 10'd4;
        freeze = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_out", int'(i_out), 0);
        check("rst_q_out", int'(q_out), 0);
        check("rst_val_out", int'(val_out), 0);
        check("rst_gain", int'(gain), 256);
        check("rst_settled", int'(settled), 0);
        reset = 1'b0;

        // Unity gain, frozen: exact pass-through, -512 clips symmetrically.
        window(100, -37, 100, -37);
        window(-512, 511, -511, 511);
        window(-1, 1, -1, 1);
        window(511, -511, 511, -511);
        check("unity_gain", int'(gain), 256);
        check("frozen_settled", int'(settled), 1);

        // Reset in the middle of traffic; in-flight samples must vanish.
        repeat (5) drive(100, -37, 100, -37);
        @(posedge clk); #1;
        reset  = 1'b1;
        val_in = 1'b0;
        sb.delete();
        #1;
        check("midrst_i_out", int'(i_out), 0);
        check("midrst_q_out", int'(q_out), 0);
        check("midrst_val_out", int'(val_out), 0);
        check("midrst_gain", int'(gain), 256);
        check("midrst_settled", int'(settled), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(4);

        // Convergence toward mean 200.
        freeze = 1'b0;
        for (int k = 0; k < 12; k++) begin
            window(50, 50, conv_out[k], conv_out[k]);
            check("conv_gain", int'(gain), conv_gain[k+1]);
        end
        for (int k = 1; k <= 4; k++) begin
            window(50, 50, 102, 102);
            check("hold_gain", int'(gain), 524);
            check("hold_settled", int'(settled), int'(k == 4));
        end

        // Saturation above unity, then frozen gain despite a low level, then release.
        freeze = 1'b1;
        window(400, -400, 511, -511);
        check("sat_gain", int'(gain), 524);
        for (int k = 0; k < 3; k++) begin
            window(25, 25, 51, 51);
            check("freeze_gain", int'(gain), 524);
        end
        freeze = 1'b0;
        window(25, 25, 51, 51);
        check("release_gain", int'(gain), 556);

        // Zero input drives gain to the upper clamp.
        pulse_reset();
        target = 10'd100;
        hyst   = 10'd4;
        nw     = 0;
        while (gain != 12'd4095 && nw < 80) begin
            window(0, 0, 0, 0);
            nw++;
        end
        check("clamp_reached", int'(gain), 4095);
        for (int k = 1; k <= 4; k++) begin
            window(0, 0, 0, 0);
            check("clamp_gain", int'(gain), 4095);
            check("clamp_settled", int'(settled), int'(k == 4));
        end

        // Over-target level steps the gain down from the clamp.
        window(10, 10, 160, 160);
        check("down_gain", int'(gain), 3840);

        idle(4);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
